// File: rtl/f_pair_monitor_if.sv
// Signal bundle between the F1/F2 logic block and its clocked observer f_pair_monitor.
// The master drives F1/F2/clr/ack and reads the counters, flags and FSM state.
interface f_pair_monitor_if #(
    parameter int CNT_W = 4
);
    logic             F1;
    logic             F2;
    logic             clr;
    logic             ack;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;
    logic             ovf1;
    logic             ovf2;
    logic             match;
    logic             timeout;
    logic [1:0]       state;

    modport master (
        output F1, F2, clr, ack,
        input  cnt1, cnt2, ovf1, ovf2, match, timeout, state
    );

    modport slave (
        input  F1, F2, clr, ack,
        output cnt1, cnt2, ovf1, ovf2, match, timeout, state
    );
endinterface

// File: rtl/f_pair_monitor.sv
// Clocked observer of F1/F2: rising-edge counters and an "F1 then F2 within WINDOW" FSM.
// Define FPM_SYNC_EN to add a two-flop synchronizer ahead of the input registers.
module f_pair_monitor #(
    parameter int CNT_W  = 4,
    parameter int WINDOW = 8
) (
    input logic              clk,
    input logic              rst,
    f_pair_monitor_if.slave  bus
);
    localparam int               TW         = $clog2(WINDOW + 1);
    localparam logic [TW-1:0]    TIMER_LAST = TW'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HIT   = 2'd2
    } state_t;

    logic f1_in, f2_in;
    logic f1_q, f1_d, f2_q, f2_d;
    logic rise1, rise2;

`ifdef FPM_SYNC_EN
    logic [1:0] f1_sync, f2_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            f1_sync <= '0;
            f2_sync <= '0;
        end else begin
            f1_sync <= {f1_sync[0], bus.F1};
            f2_sync <= {f2_sync[0], bus.F2};
        end
    end

    assign f1_in = f1_sync[1];
    assign f2_in = f2_sync[1];
`else
    assign f1_in = bus.F1;
    assign f2_in = bus.F2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            f1_q <= 1'b0;
            f1_d <= 1'b0;
            f2_q <= 1'b0;
            f2_d <= 1'b0;
        end else begin
            f1_q <= f1_in;
            f1_d <= f1_q;
            f2_q <= f2_in;
            f2_d <= f2_q;
        end
    end

    assign rise1 = f1_q & ~f1_d;
    assign rise2 = f2_q & ~f2_d;

    logic [CNT_W-1:0] cnt1_q, cnt2_q;
    logic             ovf1_q, ovf2_q;

    // clr wins over a same-cycle rise; the FSM is deliberately left alone.
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            cnt1_q <= '0;
            cnt2_q <= '0;
            ovf1_q <= 1'b0;
            ovf2_q <= 1'b0;
        end else begin
            if (rise1) begin
                if (cnt1_q == CNT_MAX) ovf1_q <= 1'b1;
                else                   cnt1_q <= cnt1_q + CNT_W'(1);
            end
            if (rise2) begin
                if (cnt2_q == CNT_MAX) ovf2_q <= 1'b1;
                else                   cnt2_q <= cnt2_q + CNT_W'(1);
            end
        end
    end

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          match_q, match_d;
    logic          timeout_q, timeout_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            match_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            match_q   <= match_d;
            timeout_q <= timeout_d;
        end
    end

    // In ARMED, rise2 outranks re-arm and expiry so a distance of exactly WINDOW still matches.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        match_d   = match_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise1) begin
                    state_d = ARMED;
                    timer_d = '0;
                end
            end
            ARMED: begin
                if (rise2) begin
                    state_d = HIT;
                    match_d = 1'b1;
                end else if (rise1) begin
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            HIT: begin
                if (bus.ack) begin
                    state_d = IDLE;
                    match_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                match_d = 1'b0;
            end
        endcase
    end

    assign bus.cnt1    = cnt1_q;
    assign bus.cnt2    = cnt2_q;
    assign bus.ovf1    = ovf1_q;
    assign bus.ovf2    = ovf2_q;
    assign bus.match   = match_q;
    assign bus.timeout = timeout_q;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_f_pair_monitor.sv
// Randomised plus directed bench for f_pair_monitor (default build, CNT_W=4, WINDOW=8).
// A per-edge reference model queues expected outputs; a negedge monitor pops and compares.
module tb_f_pair_monitor;
  localparam int CNT_W  = 4;
  localparam int WINDOW = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;
    logic             ovf1;
    logic             ovf2;
    logic             match;
    logic             timeout;
    logic [1:0]       state;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  f_pair_monitor_if #(.CNT_W(CNT_W)) bus ();

  f_pair_monitor #(.CNT_W(CNT_W), .WINDOW(WINDOW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  obs_t exp_q[$];

  // Reference model: input samples per edge, rises from the sample history,
  // window tracked as the edge number at which the current arm happened.
  bit s1[$] = '{0, 0};
  bit s2[$] = '{0, 0};
  int m_c1 = 0, m_c2 = 0, m_mode = 0, m_arm = 0, edge_n = 0;
  bit m_o1 = 0, m_o2 = 0, m_match = 0, m_to = 0;
  bit r1, r2;
  obs_t e;

  always @(posedge clk) begin
    edge_n++;
    r1 = s1[0] && !s1[1];
    r2 = s2[0] && !s2[1];
    if (rst) begin
      m_c1 = 0; m_c2 = 0; m_o1 = 0; m_o2 = 0;
      m_match = 0; m_to = 0; m_mode = 0;
    end else begin
      if (bus.clr) begin
        m_c1 = 0; m_c2 = 0; m_o1 = 0; m_o2 = 0;
      end else begin
        if (r1) begin
          if (m_c1 == CMAX) m_o1 = 1; else m_c1++;
        end
        if (r2) begin
          if (m_c2 == CMAX) m_o2 = 1; else m_c2++;
        end
      end
      m_to = 0;
      if (m_mode == 0) begin
        if (r1) begin m_mode = 1; m_arm = edge_n; end
      end else if (m_mode == 1) begin
        if (r2) begin
          m_mode = 2; m_match = 1;
        end else if (r1) begin
          m_arm = edge_n;
        end else if (edge_n - m_arm == WINDOW) begin
          m_mode = 0; m_to = 1;
        end
      end else begin
        if (bus.ack) begin m_mode = 0; m_match = 0; end
      end
    end
    e.cnt1    = CNT_W'(m_c1);
    e.cnt2    = CNT_W'(m_c2);
    e.ovf1    = m_o1;
    e.ovf2    = m_o2;
    e.match   = m_match;
    e.timeout = m_to;
    e.state   = 2'(m_mode);
    exp_q.push_back(e);
    s1.push_front(rst ? 1'b0 : bus.F1);
    s2.push_front(rst ? 1'b0 : bus.F2);
    void'(s1.pop_back());
    void'(s2.pop_back());
  end

  obs_t got, want;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got.cnt1    = bus.cnt1;
      got.cnt2    = bus.cnt2;
      got.ovf1    = bus.ovf1;
      got.ovf2    = bus.ovf2;
      got.match   = bus.match;
      got.timeout = bus.timeout;
      got.state   = bus.state;
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL outputs edge=%0d got cnt1=%0d cnt2=%0d ovf=%b%b match=%b to=%b st=%0d exp cnt1=%0d cnt2=%0d ovf=%b%b match=%b to=%b st=%0d",
                 edge_n, got.cnt1, got.cnt2, got.ovf1, got.ovf2, got.match, got.timeout, got.state,
                 want.cnt1, want.cnt2, want.ovf1, want.ovf2, want.match, want.timeout, want.state);
      end
    end
  end

  task automatic check_val(input string what, input int got_v, input int exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0d exp=%0d", what, edge_n, got_v, exp_v);
    end
  endtask

  task automatic drive(input bit f1, input bit f2, input bit c, input bit a, input bit r);
    bus.F1  = f1;
    bus.F2  = f2;
    bus.clr = c;
    bus.ack = a;
    rst     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    bit f1, f2;
    int to_seen;
    bus.F1 = 1'b1; bus.F2 = 1'b1; bus.clr = 1'b0; bus.ack = 1'b0;

    // Reset with both inputs high, then release: each counts one rise.
    repeat (3) drive(1, 1, 0, 0, 1);
    check_val("reset cnt1", int'(bus.cnt1), 0);
    check_val("reset cnt2", int'(bus.cnt2), 0);
    check_val("reset ovf", int'({bus.ovf1, bus.ovf2}), 0);
    check_val("reset match", int'(bus.match), 0);
    check_val("reset timeout", int'(bus.timeout), 0);
    check_val("reset state", int'(bus.state), 0);
    repeat (3) drive(1, 1, 0, 0, 0);
    idle(4);

    // F1 then F2 four edges later, then acknowledge.
    repeat (4) drive(1, 0, 0, 0, 0);
    repeat (3) drive(1, 1, 0, 0, 0);
    idle(2);
    drive(0, 0, 0, 1, 0);
    idle(2);

    // F1 alone: window expires.
    drive(1, 0, 0, 0, 0);
    to_seen = 0;
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 0, 0, 0);
      to_seen += int'(bus.timeout);
    end
    check_val("expired timeout pulses", to_seen, 1);
    check_val("expired state", int'(bus.state), 0);
    check_val("expired match", int'(bus.match), 0);

    // Distances WINDOW and WINDOW+1, then simultaneous rises.
    for (int d = WINDOW; d <= WINDOW + 1; d++) begin
      for (int i = 0; i <= d; i++) drive(i == 0, i == d, 0, 0, 0);
      idle(3);
      drive(0, 0, 0, 1, 0);
      idle(10);
    end
    drive(1, 1, 0, 0, 0);
    idle(12);

    // Counter saturation, then clr colliding with a rise.
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
    end
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0);
    idle(3);

    // Reset in the middle of a window.
    repeat (2) drive(1, 0, 0, 0, 0);
    idle(2);
    drive(0, 0, 0, 0, 1);
    idle(12);

    // Random traffic.
    f1 = 0; f2 = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(3) == 0) f1 = ~f1;
      if ($urandom_range(4) == 0) f2 = ~f2;
      drive(f1, f2, $urandom_range(39) == 0, $urandom_range(5) == 0,
            $urandom_range(199) == 0);
    end
    idle(3);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
